// File: rtl/memshare_rqst_addr_gen_pkg.sv
// memshare_rqst_addr_gen_pkg: shared configuration for the memShare read-request address generator
//   MEMSHARE_DRC_NUM        default number of DRC channels
//   MEMSHARE_DRC0/1         DRC channel indices (channel 0 never rebases the step)
//   MSGPASS_ADDR_*          message-passing buffer window defaults
//   memshare_rqst_state_e   FSM state type with ST_IDLE/ST_RUN/ST_DONE encodings
package memshare_rqst_addr_gen_pkg;
  localparam int MEMSHARE_DRC_NUM = 2;
  localparam int MEMSHARE_DRC0 = 0;
  localparam int MEMSHARE_DRC1 = 1;
  localparam int MSGPASS_ADDR_WIDTH = 6;
  localparam int MSGPASS_ADDR_BASE = 0;
  localparam int MSGPASS_ADDR_MAX = 47;
  typedef logic [1:0] memshare_rqst_state_e;
  localparam memshare_rqst_state_e ST_IDLE = 2'd0;
  localparam memshare_rqst_state_e ST_RUN = 2'd1;
  localparam memshare_rqst_state_e ST_DONE = 2'd2;
endpackage

// File: rtl/memshare_rqst_addr_gen_pipereg.sv
// pipeReg_insert: enable-gated delay line of PIPELINE_STAGE registers
//   sys_clk    clock
//   rstn       asynchronous active-low reset, clears every stage
//   load_en_i  shift enable; all stages hold when low
//   d_i        value entering the line
//   q_o        value that entered PIPELINE_STAGE enabled cycles ago
module pipeReg_insert #(
  parameter int BITWIDTH = 3,
  parameter int PIPELINE_STAGE = 2
) (
  input  logic                sys_clk,
  input  logic                rstn,
  input  logic                load_en_i,
  input  logic [BITWIDTH-1:0] d_i,
  output logic [BITWIDTH-1:0] q_o
);
  logic [BITWIDTH-1:0] stage_q [PIPELINE_STAGE];
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < PIPELINE_STAGE; i++) stage_q[i] <= '0;
    end else if (load_en_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < PIPELINE_STAGE; i++) stage_q[i] <= stage_q[i-1];
    end
  end
  assign q_o = stage_q[PIPELINE_STAGE-1];
endmodule

// File: rtl/memshare_rqst_addr_gen.sv
// memshare_rqst_addr_gen: read-request address generator for the message-passing buffer in memShare
//   sys_clk              clock
//   rstn                 asynchronous active-low reset
//   scu_begin_i          start / restart pulse, rebases to ADDR_BASE
//   rqst_num_i           number of requests, latched on scu_begin_i
//   is_drc_i             per-channel DRC flags; lowest set bit >=1 selects that channel's tracked operand
//   operand_i            per-channel increment operands, channel k in slice k
//   stall_i              back-pressure; freezes address, count, increment and operand track
//   rqst_addr_o          registered request address
//   rqst_valid_o         registered request valid
//   increment_operand_o  registered increment that produced rqst_addr_o
//   busy_o               high while running
//   done_o               one-cycle completion pulse
module memshare_rqst_addr_gen
  import memshare_rqst_addr_gen_pkg::*;
#(
  parameter int DRC_NUM = MEMSHARE_DRC_NUM,
  parameter int ADDR_WIDTH = MSGPASS_ADDR_WIDTH,
  parameter int OPERAND_WIDTH = 3,
  parameter int TRACK_DEPTH = 2,
  parameter int CNT_WIDTH = 6,
  parameter int ADDR_BASE = MSGPASS_ADDR_BASE,
  parameter int ADDR_MAX = MSGPASS_ADDR_MAX
) (
  input  logic                               sys_clk,
  input  logic                               rstn,
  input  logic                               scu_begin_i,
  input  logic [CNT_WIDTH-1:0]               rqst_num_i,
  input  logic [DRC_NUM-1:0]                 is_drc_i,
  input  logic [DRC_NUM*OPERAND_WIDTH-1:0]   operand_i,
  input  logic                               stall_i,
  output logic [ADDR_WIDTH-1:0]              rqst_addr_o,
  output logic                               rqst_valid_o,
  output logic [OPERAND_WIDTH-1:0]           increment_operand_o,
  output logic                               busy_o,
  output logic                               done_o
);
  localparam int WIN = ADDR_MAX - ADDR_BASE + 1;
  // A single wrap subtraction is only correct while any step is smaller than the window.
  if (TRACK_DEPTH < 1 || ADDR_MAX <= ADDR_BASE || ADDR_MAX >= (1 << ADDR_WIDTH) ||
      (1 << OPERAND_WIDTH) - 1 >= WIN) begin : g_bad_params
    $error("memshare_rqst_addr_gen: illegal parameter combination");
  end
  memshare_rqst_state_e state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [OPERAND_WIDTH-1:0] inc_q, inc_d, inc;
  logic valid_q, valid_d, fresh_q, fresh_d;
  logic [OPERAND_WIDTH-1:0] trk [DRC_NUM];
  logic [ADDR_WIDTH:0] sum, nxt;
  logic run, start, adv, rel, last, unused_ok;
  for (genvar k = 0; k < DRC_NUM; k++) begin : g_trk
    pipeReg_insert #(.BITWIDTH(OPERAND_WIDTH), .PIPELINE_STAGE(TRACK_DEPTH)) u_trk (
      .sys_clk  (sys_clk),
      .rstn     (rstn),
      .load_en_i(!stall_i),
      .d_i      (operand_i[k*OPERAND_WIDTH +: OPERAND_WIDTH]),
      .q_o      (trk[k])
    );
  end
  // Walk downwards so the lowest flagged channel above 0 has the last word.
  always_comb begin
    inc = OPERAND_WIDTH'(1);
    for (int k = DRC_NUM - 1; k >= MEMSHARE_DRC1; k--) if (is_drc_i[k]) inc = trk[k];
  end
  assign sum = {1'b0, addr_q} + (ADDR_WIDTH+1)'(inc);
  assign nxt = sum > (ADDR_WIDTH+1)'(ADDR_MAX) ? sum - (ADDR_WIDTH+1)'(WIN) : sum;
  assign run = state_q == ST_RUN;
  assign start = scu_begin_i;
  // fresh_q marks a restart that met a stall: ADDR_BASE is still owed as the first request.
  assign rel = run && !stall_i && fresh_q && !start;
  assign adv = run && !stall_i && !fresh_q && !start;
  assign last = adv && cnt_q == CNT_WIDTH'(1);
  always_comb begin
    state_d = start ? (rqst_num_i == '0 ? ST_DONE : ST_RUN) : !run ? ST_IDLE : last ? ST_DONE : ST_RUN;
    addr_d = start ? ADDR_WIDTH'(ADDR_BASE) : (adv && !last) ? nxt[ADDR_WIDTH-1:0] : addr_q;
    cnt_d = start ? rqst_num_i : adv ? cnt_q - CNT_WIDTH'(1) : cnt_q;
    inc_d = start ? '0 : (adv && !last) ? inc : inc_q;
    valid_d = start ? (!stall_i && rqst_num_i != '0) : (adv && !last) || rel;
    fresh_d = start ? (stall_i && rqst_num_i != '0) : rel ? 1'b0 : fresh_q;
  end
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q <= ADDR_WIDTH'(ADDR_BASE);
      cnt_q <= '0;
      inc_q <= '0;
      valid_q <= 1'b0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      inc_q <= inc_d;
      valid_q <= valid_d;
      fresh_q <= fresh_d;
    end
  end
  assign rqst_addr_o = addr_q;
  assign rqst_valid_o = valid_q;
  assign increment_operand_o = inc_q;
  assign busy_o = run;
  assign done_o = state_q == ST_DONE;
  // Channel 0 only means "no rebase", so its flag and operand never steer the step.
  assign unused_ok = ^{is_drc_i[MEMSHARE_DRC0], trk[MEMSHARE_DRC0], nxt[ADDR_WIDTH]};
endmodule

// File: tb/tb_memshare_rqst_addr_gen.sv
// tb_memshare_rqst_addr_gen: directed and random stimulus against a transaction-level reference model
module tb_memshare_rqst_addr_gen;
  localparam int DRC = 2, AW = 6, OW = 3, TD = 2, CW = 6, BASE = 0, MAX = 47, WIN = MAX - BASE + 1;
  logic sys_clk = 1'b0, rstn = 1'b0, scu_begin_i = 1'b0, stall_i = 1'b0;
  logic [CW-1:0] rqst_num_i = '0;
  logic [DRC-1:0] is_drc_i = '0;
  logic [DRC*OW-1:0] operand_i = '0;
  logic [AW-1:0] rqst_addr_o;
  logic rqst_valid_o, busy_o, done_o;
  logic [OW-1:0] increment_operand_o;
  int n_chk = 0, n_fail = 0, n_done = 0;
  int m_mode, m_addr, m_left, m_inc, m_step;
  bit m_valid, m_wait;
  logic [DRC*OW-1:0] hist [$];
  int seen [$];
  int incs [$];
  memshare_rqst_addr_gen #(
    .DRC_NUM(DRC), .ADDR_WIDTH(AW), .OPERAND_WIDTH(OW), .TRACK_DEPTH(TD),
    .CNT_WIDTH(CW), .ADDR_BASE(BASE), .ADDR_MAX(MAX)
  ) dut (
    .sys_clk(sys_clk), .rstn(rstn), .scu_begin_i(scu_begin_i), .rqst_num_i(rqst_num_i),
    .is_drc_i(is_drc_i), .operand_i(operand_i), .stall_i(stall_i),
    .rqst_addr_o(rqst_addr_o), .rqst_valid_o(rqst_valid_o),
    .increment_operand_o(increment_operand_o), .busy_o(busy_o), .done_o(done_o)
  );
  always #5 sys_clk = ~sys_clk;
  // Reference: mode 0 idle, 1 running, 2 finishing; hist[0] is the operand seen TD enabled cycles ago.
  always @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_addr = BASE; m_left = 0; m_inc = 0; m_valid = 0; m_wait = 0;
      hist.delete();
      repeat (TD) hist.push_back('0);
    end else begin
      m_step = 1;
      for (int k = 1; k < DRC; k++)
        if (is_drc_i[k]) begin m_step = int'((hist[0] >> (k * OW)) & ((1 << OW) - 1)); break; end
      if (scu_begin_i) begin
        m_mode = rqst_num_i == 0 ? 2 : 1; m_addr = BASE; m_left = rqst_num_i; m_inc = 0;
        m_wait = stall_i && rqst_num_i != 0; m_valid = !stall_i && rqst_num_i != 0;
      end else if (m_mode == 2) begin
        m_mode = 0; m_valid = 0;
      end else if (m_mode == 1) begin
        if (stall_i) m_valid = 0;
        else if (m_wait) begin m_wait = 0; m_valid = 1; end
        else if (m_left == 1) begin m_mode = 2; m_left = 0; m_valid = 0; end
        else begin
          m_addr = m_addr + m_step;
          if (m_addr > MAX) m_addr = m_addr - WIN;
          m_inc = m_step; m_left = m_left - 1; m_valid = 1;
        end
      end
      if (!stall_i) begin hist.push_back(operand_i); void'(hist.pop_front()); end
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic compare();
    chk("valid", 32'(rqst_valid_o), 32'(m_valid));
    chk("addr", 32'(rqst_addr_o), 32'(m_addr));
    chk("inc", 32'(increment_operand_o), 32'(m_inc));
    chk("busy", 32'(busy_o), 32'(m_mode == 1));
    chk("done", 32'(done_o), 32'(m_mode == 2));
    if (rqst_valid_o) begin seen.push_back(int'(rqst_addr_o)); incs.push_back(int'(increment_operand_o)); end
    if (done_o) n_done++;
  endtask
  task automatic step(input logic b, input int n, input logic [DRC-1:0] d, input logic [DRC*OW-1:0] op, input logic s);
    scu_begin_i = b; rqst_num_i = CW'(n); is_drc_i = d; operand_i = op; stall_i = s;
    @(negedge sys_clk);
    compare();
  endtask
  task automatic clear();
    seen.delete(); incs.delete(); n_done = 0;
  endtask
  initial begin
    repeat (2) @(negedge sys_clk);
    rstn = 1'b1;
    chk("rst_addr", 32'(rqst_addr_o), BASE);
    chk("rst_valid", 32'(rqst_valid_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    // plain run of 5
    clear();
    step(1, 5, 0, 0, 0);
    repeat (7) step(0, 0, 0, 0, 0);
    chk("plain_cnt", seen.size(), 5);
    for (int i = 0; i < 5; i++) chk("plain_addr", seen[i], i);
    chk("plain_done", n_done, 1);
    // DRC1 steps of 3 from the third request, wrapping 46 -> 1
    clear();
    repeat (3) step(0, 0, 0, 6'o30, 0);
    step(1, 18, 0, 6'o30, 0);
    step(0, 0, 0, 6'o30, 0);
    repeat (20) step(0, 0, 2'b10, 6'o30, 0);
    chk("drc_cnt", seen.size(), 18);
    chk("drc_a0", seen[0], 0); chk("drc_a1", seen[1], 1); chk("drc_a2", seen[2], 4);
    chk("drc_a3", seen[3], 7); chk("drc_a4", seen[4], 10);
    chk("drc_i1", incs[1], 1); chk("drc_i2", incs[2], 3);
    chk("wrap_pre", seen[16], 46); chk("wrap_post", seen[17], 1);
    // stall 3 cycles after addr 2
    clear();
    step(1, 5, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (3) begin step(0, 0, 0, 0, 1); chk("stall_valid", 32'(rqst_valid_o), 0); end
    repeat (5) step(0, 0, 0, 0, 0);
    chk("stall_cnt", seen.size(), 5);
    chk("stall_resume", seen[3], 3);
    // restart at addr 3 of a 10-run, then zero count
    clear();
    step(1, 10, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0);
    step(1, 4, 0, 0, 0);
    chk("restart_addr", 32'(rqst_addr_o), 0);
    repeat (6) step(0, 0, 0, 0, 0);
    chk("restart_cnt", seen.size(), 8);
    chk("restart_done", n_done, 1);
    clear();
    step(1, 0, 0, 0, 0);
    chk("zero_done", 32'(done_o), 1);
    step(0, 0, 0, 0, 0);
    chk("zero_cnt", seen.size(), 0);
    // restart coinciding with stall
    clear();
    step(1, 3, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("bstall_cnt", seen.size(), 3);
    chk("bstall_first", seen[0], 0);
    chk("bstall_last", seen[2], 2);
    // asynchronous reset mid-run
    step(1, 20, 0, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0);
    chk("pre_rst_addr", 32'(rqst_addr_o), 5);
    #2 rstn = 1'b0;
    #1;
    chk("arst_addr", 32'(rqst_addr_o), BASE);
    chk("arst_valid", 32'(rqst_valid_o), 0);
    chk("arst_inc", 32'(increment_operand_o), 0);
    chk("arst_busy", 32'(busy_o), 0);
    chk("arst_done", 32'(done_o), 0);
    @(negedge sys_clk);
    rstn = 1'b1;
    // random traffic
    repeat (600)
      step($urandom_range(0, 24) == 0, $urandom_range(0, 40), DRC'($urandom),
           (DRC*OW)'($urandom), $urandom_range(0, 3) == 0);
    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end
endmodule
